// File: rtl/md_ctrl.sv
// Issue/hazard controller between the E stage and the multiply/divide unit:
// drives md controls, stalls while md is busy, stretches reset, watchdogs md.
module md_ctrl #(
  parameter int MUL_LAT   = 6,
  parameter int DIV_LAT   = 11,
  parameter int TO_MARGIN = 4,
  parameter int RST_HOLD  = 2,
  parameter int CNT_W     = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        E_MdStart,
  input  logic [1:0]  E_MdOp,
  input  logic        E_Madd,
  input  logic        E_MtReq,
  input  logic        E_MfReq,
  input  logic        E_HiLo,
  input  logic [31:0] E_D2,
  input  logic        Flush,
  input  logic        Md_Busy,
  output logic        Md_Rst,
  output logic        Md_Start,
  output logic [1:0]  Md_Op,
  output logic        Md_isMADDE,
  output logic        Md_We,
  output logic        Md_HiLo,
  output logic        Stall,
  output logic        DivZero,
  output logic        Err,
  output logic [31:0] StallCnt
);

  typedef enum logic [1:0] {RSTW = 2'd0, IDLE = 2'd1, RUN = 2'd2} state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  // Timeout limits fold the margin in so RUN compares against one register.
  localparam logic [CNT_W-1:0]  MUL_LIM   = CNT_W'(MUL_LAT + TO_MARGIN);
  localparam logic [CNT_W-1:0]  DIV_LIM   = CNT_W'(DIV_LAT + TO_MARGIN);

  state_t              r_state, w_state_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_lim, w_lim_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_divzero;
  logic                r_err;
  logic [31:0]         r_stallcnt;
  logic                w_md_class;
  logic                w_in_rstw;
  logic                w_issue;
  logic                w_mt;
  logic                w_err_set;
  logic                w_stall;

  assign w_md_class = E_MdStart | E_MtReq | E_MfReq;
  assign w_in_rstw  = (r_state == RSTW);
  assign w_issue    = E_MdStart & ~Flush & ~Md_Busy & ~w_in_rstw;
  // Start wins over a (decode-illegal) simultaneous move-to.
  assign w_mt       = E_MtReq & ~E_MdStart & ~Flush & ~Md_Busy & ~w_in_rstw;
  assign w_stall    = w_md_class & ~Flush & (w_in_rstw | Md_Busy);
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  assign Md_Rst     = w_in_rstw;
  assign Md_Start   = w_issue;
  assign Md_We      = w_mt;
  assign Md_Op      = E_MdOp;
  assign Md_isMADDE = E_Madd;
  assign Md_HiLo    = E_HiLo;
  assign Stall      = w_stall;
  assign DivZero    = r_divzero;
  assign Err        = r_err;
  assign StallCnt   = r_stallcnt;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_cnt_nxt   = r_cnt;
    w_lim_nxt   = r_lim;
    w_err_set   = 1'b0;
    case (r_state)
      RSTW: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold + HOLD_ONE;
        end
      end
      IDLE: ;
      RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (!Md_Busy) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_inc == r_lim) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = RSTW;
    endcase
    // A new issue overrides whatever RUN decided on its last Busy-low cycle.
    if (w_issue) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
      w_lim_nxt   = E_MdOp[1] ? DIV_LIM : MUL_LIM;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= RSTW;
      r_hold     <= '0;
      r_cnt      <= '0;
      r_lim      <= '0;
      r_divzero  <= 1'b0;
      r_err      <= 1'b0;
      r_stallcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lim   <= w_lim_nxt;
      if (w_issue) begin
        r_divzero <= E_MdOp[1] & (E_D2 == 32'd0);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_stall && (r_stallcnt != 32'hFFFF_FFFF)) begin
        r_stallcnt <= r_stallcnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: stimulus pushes timed expectations and expected
// Start/We events into queues; a negedge monitor pops and compares them.
module tb_md_ctrl;

  logic        Clk;
  logic        Rst;
  logic        E_MdStart;
  logic [1:0]  E_MdOp;
  logic        E_Madd;
  logic        E_MtReq;
  logic        E_MfReq;
  logic        E_HiLo;
  logic [31:0] E_D2;
  logic        Flush;
  logic        Md_Busy;
  logic        Md_Rst;
  logic        Md_Start;
  logic [1:0]  Md_Op;
  logic        Md_isMADDE;
  logic        Md_We;
  logic        Md_HiLo;
  logic        Stall;
  logic        DivZero;
  logic        Err;
  logic [31:0] StallCnt;

  md_ctrl dut (
    .Clk(Clk), .Rst(Rst), .E_MdStart(E_MdStart), .E_MdOp(E_MdOp),
    .E_Madd(E_Madd), .E_MtReq(E_MtReq), .E_MfReq(E_MfReq), .E_HiLo(E_HiLo),
    .E_D2(E_D2), .Flush(Flush), .Md_Busy(Md_Busy), .Md_Rst(Md_Rst),
    .Md_Start(Md_Start), .Md_Op(Md_Op), .Md_isMADDE(Md_isMADDE), .Md_We(Md_We),
    .Md_HiLo(Md_HiLo), .Stall(Stall), .DivZero(DivZero), .Err(Err),
    .StallCnt(StallCnt)
  );

  localparam int S_RST = 0, S_START = 1, S_WE = 2, S_STALL = 3, S_DZ = 4;
  localparam int S_ERR = 5, S_SCNT = 6, S_OP = 7, S_HILO = 8, S_MADD = 9;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    int   cyc;
    logic st;
    logic we;
  } ev_t;

  exp_t q[$];
  ev_t  evq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic string sname(input int s);
    case (s)
      S_RST:   return "Md_Rst";
      S_START: return "Md_Start";
      S_WE:    return "Md_We";
      S_STALL: return "Stall";
      S_DZ:    return "DivZero";
      S_ERR:   return "Err";
      S_SCNT:  return "StallCnt";
      S_OP:    return "Md_Op";
      S_HILO:  return "Md_HiLo";
      default: return "Md_isMADDE";
    endcase
  endfunction

  function automatic logic [31:0] sval(input int s);
    case (s)
      S_RST:   return {31'd0, Md_Rst};
      S_START: return {31'd0, Md_Start};
      S_WE:    return {31'd0, Md_We};
      S_STALL: return {31'd0, Stall};
      S_DZ:    return {31'd0, DivZero};
      S_ERR:   return {31'd0, Err};
      S_SCNT:  return StallCnt;
      S_OP:    return {30'd0, Md_Op};
      S_HILO:  return {31'd0, Md_HiLo};
      default: return {31'd0, Md_isMADDE};
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ex(input int sel, input logic [31:0] val);
    q.push_back('{cyc, sel, val});
  endtask

  task automatic ev(input logic st, input logic we);
    evq.push_back('{cyc, st, we});
  endtask

  // Monitor: timed expectations and Start/We events, sampled mid-cycle.
  always @(negedge Clk) begin
    exp_t        e;
    ev_t         v;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = sval(e.sel);
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", sname(e.sel), e.cyc, cyc);
      end else if (act !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", sname(e.sel), cyc, act, e.val);
      end
    end
    if (evq.size() > 0 && evq[0].cyc < cyc) begin
      v = evq.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event cyc=%0d got=none exp=start%0b/we%0b", v.cyc, v.st, v.we);
    end
    if (Md_Start || Md_We) begin
      checks++;
      if (evq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got=start%0b/we%0b exp=none", cyc, Md_Start, Md_We);
      end else begin
        v = evq.pop_front();
        if (v.cyc != cyc || v.st !== Md_Start || v.we !== Md_We) begin
          failures++;
          $display("FAIL event cyc=%0d got=start%0b/we%0b exp=cyc%0d start%0b/we%0b",
                   cyc, Md_Start, Md_We, v.cyc, v.st, v.we);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    Rst = 1'b0; E_MdStart = 1'b0; E_MdOp = 2'b00; E_Madd = 1'b0; E_MtReq = 1'b0;
    E_MfReq = 1'b0; E_HiLo = 1'b0; E_D2 = 32'd0; Flush = 1'b0; Md_Busy = 1'b0;

    // Reset held: controls suppressed, status cleared, RSTW stall rule.
    step;
    E_MdStart = 1'b1; E_MdOp = 2'b01;
    ex(S_RST, 1); ex(S_START, 0); ex(S_DZ, 0); ex(S_ERR, 0); ex(S_SCNT, 0); ex(S_STALL, 1);
    step;
    E_MdStart = 1'b0; E_MtReq = 1'b1;
    ex(S_WE, 0); ex(S_STALL, 1); ex(S_RST, 1);
    step;
    E_MtReq = 1'b0;
    // Release with mf pending: Md_Rst holds for two edges, stalls counted.
    step;
    Rst = 1'b1; E_MfReq = 1'b1;
    ex(S_RST, 1); ex(S_STALL, 1); ex(S_WE, 0);
    step;
    ex(S_RST, 1); ex(S_STALL, 1);
    step;
    ex(S_RST, 0); ex(S_STALL, 0); ex(S_SCNT, 2);
    E_MfReq = 1'b0;

    // Fresh reset so the stall count starts at zero.
    step;
    Rst = 1'b0;
    step;
    Rst = 1'b1;
    ex(S_RST, 1);
    step;
    step;
    ex(S_RST, 0); ex(S_SCNT, 0);

    // madd issue then mfhi stalled for six Busy cycles.
    E_MdStart = 1'b1; E_MdOp = 2'b01; E_Madd = 1'b1; E_D2 = 32'd7;
    ex(S_START, 1); ex(S_OP, 1); ex(S_MADD, 1); ex(S_STALL, 0); ev(1, 0);
    step;
    E_MdStart = 1'b0; E_Madd = 1'b0; E_MfReq = 1'b1; E_HiLo = 1'b1; Md_Busy = 1'b1;
    ex(S_HILO, 1);
    for (int k = 0; k < 6; k++) begin
      ex(S_STALL, 1); ex(S_START, 0);
      step;
    end
    Md_Busy = 1'b0;
    ex(S_STALL, 0); ex(S_WE, 0); ex(S_SCNT, 6); ex(S_ERR, 0);
    step;
    E_MfReq = 1'b0; E_HiLo = 1'b0;

    // Divide by zero, then back-to-back multu on the Busy-low RUN cycle.
    E_MdStart = 1'b1; E_MdOp = 2'b11; E_D2 = 32'd0;
    ex(S_START, 1); ex(S_DZ, 0); ev(1, 0);
    step;
    E_MdOp = 2'b00; E_D2 = 32'd5;
    ex(S_DZ, 1); ex(S_START, 1); ev(1, 0);
    step;
    E_MdStart = 1'b0;
    ex(S_DZ, 0);
    step;

    // Flushed start, flushed mt, flushed mf with Busy high.
    E_MdStart = 1'b1; E_MdOp = 2'b01; Flush = 1'b1;
    ex(S_START, 0); ex(S_STALL, 0);
    step;
    E_MdStart = 1'b0; E_MtReq = 1'b1;
    ex(S_WE, 0);
    step;
    E_MtReq = 1'b0; E_MfReq = 1'b1; Md_Busy = 1'b1;
    ex(S_STALL, 0);
    step;
    Flush = 1'b0; E_MfReq = 1'b0; Md_Busy = 1'b0;

    // mthi held off while md busy, written on the first Busy-low cycle.
    E_MdStart = 1'b1; E_MdOp = 2'b00;
    ex(S_START, 1); ev(1, 0);
    step;
    E_MdStart = 1'b0; Md_Busy = 1'b1; E_MtReq = 1'b1; E_HiLo = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ex(S_WE, 0); ex(S_STALL, 1);
      step;
    end
    Md_Busy = 1'b0;
    ex(S_WE, 1); ex(S_STALL, 0); ex(S_HILO, 1); ex(S_SCNT, 9); ev(0, 1);
    step;
    E_MtReq = 1'b0; E_HiLo = 1'b0;

    // Start and mt together: start wins.
    E_MdStart = 1'b1; E_MtReq = 1'b1; E_MdOp = 2'b10; E_D2 = 32'd3;
    ex(S_START, 1); ex(S_WE, 0); ex(S_OP, 2); ev(1, 0);
    step;
    E_MdStart = 1'b0; E_MtReq = 1'b0;
    ex(S_DZ, 0);
    step;

    // Timeout: div with Busy stuck high sets Err after 15 RUN cycles.
    E_MdStart = 1'b1; E_MdOp = 2'b11; E_D2 = 32'd9;
    ex(S_START, 1); ev(1, 0);
    step;
    E_MdStart = 1'b0; Md_Busy = 1'b1;
    for (int r = 0; r < 15; r++) begin
      ex(S_ERR, 0);
      step;
    end
    E_MfReq = 1'b1;
    ex(S_ERR, 1); ex(S_STALL, 1);
    step;
    E_MfReq = 1'b0; Md_Busy = 1'b0;
    ex(S_ERR, 1); ex(S_STALL, 0); ex(S_SCNT, 10);
    step;
    ex(S_ERR, 1);

    // Reset four cycles into a div-by-zero clears everything at once.
    E_MdStart = 1'b1; E_MdOp = 2'b11; E_D2 = 32'd0;
    ex(S_START, 1); ev(1, 0);
    step;
    E_MdStart = 1'b0; Md_Busy = 1'b1; E_MfReq = 1'b1;
    ex(S_DZ, 1); ex(S_ERR, 1); ex(S_STALL, 1);
    step;
    step;
    step;
    Rst = 1'b0; E_MdStart = 1'b1;
    ex(S_RST, 1); ex(S_ERR, 0); ex(S_DZ, 0); ex(S_SCNT, 0); ex(S_STALL, 1); ex(S_START, 0);
    step;
    Rst = 1'b1; E_MdStart = 1'b0; E_MfReq = 1'b0; Md_Busy = 1'b0;
    step;
    step;
    ex(S_RST, 0); ex(S_ERR, 0);
    step;

    @(negedge Clk);
    #1;
    checks++;
    if (q.size() != 0 || evq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", q.size(), evq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Issue and hazard controller for the pipeline's multiply/divide unit (md).
- Sits between the E stage and md, translating E-stage MD-class instructions (mult/multu/div/divu/madd, mthi/mtlo, mfhi/mflo) into md's Start/We/Op/HiLo/isMADDE controls.
- Stalls the pipeline while md is busy and stretches a synchronous reset into md.
- Flags divide-by-zero, watchdogs md completion, and counts stall cycles.

Parameters:
- MUL_LAT, 6: expected md Busy-high cycles for Op 00/01.
- DIV_LAT, 11: expected md Busy-high cycles for Op 10/11.
- TO_MARGIN, 4: extra cycles beyond expected latency before timeout.
- RST_HOLD, 2: cycles Md_Rst stays high after Rst deasserts.
- CNT_W, 8: width of internal latency counter.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- E_MdStart  in  1  E stage holds mult/multu/div/divu/madd.
- E_MdOp  in  2  00 multu, 01 mult/madd, 10 divu, 11 div.
- E_Madd  in  1  E instruction is madd (accumulate).
- E_MtReq  in  1  E stage holds mthi/mtlo.
- E_MfReq  in  1  E stage holds mfhi/mflo.
- E_HiLo  in  1  1=HI, 0=LO for mt/mf.
- E_D2  in  32  divisor operand, for zero detect.
- Flush  in  1  E stage instruction is being killed (exception/eret).
- Md_Busy  in  1  md Busy output.
- Md_Rst  out  1  synchronous active-high reset to md.
- Md_Start  out  1  md Start.
- Md_Op  out  2  md Op (passthrough of E_MdOp).
- Md_isMADDE  out  1  md isMADDE (passthrough of E_Madd).
- Md_We  out  1  md We.
- Md_HiLo  out  1  md HiLo (passthrough of E_HiLo).
- Stall  out  1  freeze F/D/E, bubble into M.
- DivZero  out  1  last issued op was a divide by zero.
- Err  out  1  sticky md timeout error.
- StallCnt  out  32  saturating count of Stall cycles.

Behaviour:
- **Reset (Rst=0, async):**
  - State=RSTW; Md_Rst=1; DivZero=0, Err=0, StallCnt=0; internal counters 0.
  - Md_Start=0 and Md_We=0 irrespective of inputs.
- **FSM states:** RSTW, IDLE, RUN.
- **RSTW:**
  - After Rst rises, Md_Rst stays 1 for exactly RST_HOLD rising edges, then drops and state goes to IDLE.
  - md_class = E_MdStart|E_MtReq|E_MfReq. Stall = md_class && !Flush throughout RSTW.
- **Stall (combinational), outside RSTW:** Stall = md_class && !Flush && Md_Busy.
- **Issue:** Md_Start = E_MdStart && !Flush && !Md_Busy && state!=RSTW.
  - Issue takes effect whether state is IDLE or RUN; the RUN case covers the final cycle with Busy low.
  - On issue: state goes to RUN; latency counter resets to 0; expected latency is latched as MUL_LAT if E_MdOp[1]=0, else DIV_LAT.
  - DivZero is set to (E_MdOp[1] && E_D2==0) on every issue and holds until the next issue.
- **Move-to:** Md_We = E_MtReq && !Flush && !Md_Busy && state!=RSTW.
  - mt is never issued while md is busy; md would otherwise let the pending result overwrite it.
- **RUN:**
  - Counter increments each cycle.
  - If Md_Busy=0 and there is no issue this cycle, go to IDLE.
  - If the counter reaches expected latency + TO_MARGIN with Md_Busy still 1: set Err=1 (sticky until Rst), go to IDLE.
  - Stall still follows Md_Busy after a timeout; Err is status only.
- **Flush:** suppresses Start/We/Stall for the killed instruction. A flush during RUN does not cancel md; the operation completes and state tracking continues.
- **Simultaneous requests:** E_MdStart and E_MtReq together are illegal by decode. If both arrive, Start wins and We is suppressed.
- **StallCnt:** +1 on each cycle with Stall=1; saturates at 32'hFFFF_FFFF, no wrap.
- **Reset mid-operation:** state goes to RSTW immediately; Md_Rst=1 clears md Busy; Err and DivZero are cleared.
- **Latency:** the controller adds no pipeline latency; all md controls are combinational from E inputs plus registered state.

Test Plan:
- **Reset stretch:** Rst low 3 cycles then high, RST_HOLD=2 -> Md_Rst=1 through reset plus exactly 2 edges, then 0. E_MfReq=1 during RSTW -> Stall=1, Md_We=0.
- **mult then mfhi:** E_MdStart, Op=01 with Busy=0 -> Md_Start=1 for 1 cycle. Next cycle E_MfReq=1, bench md holds Busy 6 cycles -> Stall=1 for exactly 6 cycles, StallCnt=6, Err=0.
- **Divide by zero:** issue Op=11 with E_D2=0 -> DivZero=1 from next cycle. Issue Op=00 with E_D2=5 -> DivZero=0.
- **Flush:** E_MdStart=1 and Flush=1 same cycle -> Md_Start=0, state stays IDLE. mthi with Busy=1 and Flush=0 -> Md_We=0 and Stall=1 until Busy falls, then Md_We=1 for 1 cycle.
- **Timeout:** issue div, bench holds Busy=1 forever -> Err=1 after 15 RUN cycles (11+4), state IDLE. Err stays 1 until Rst.
- **Reset mid-op:** assert Rst low 4 cycles after div issue -> Md_Rst=1 asynchronously; Err=0, DivZero=0, StallCnt=0.
